mem_access_ctrl: RTL and testbench

//  MEM-stage data-memory sequencer for the pipeline. Accepts one load/store per instruction.

---
 rtl/mem_access_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory sequencer.
// Decodes MIPS load/store opcodes, checks alignment, runs a req/ack
// handshake with a bounded wait, and delivers extended load data while
// holding the pipeline in stall for the duration of the access.
module mem_access_ctrl #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misaligned,
    output logic        bus_error,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    // Counter just wide enough to reach TIMEOUT_CYC-1
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;

    // Decoded view of the incoming instruction
    logic              op_is_mem;
    logic              op_is_load;
    logic              op_signed;
    size_t             op_size;
    logic              addr_misaligned;
    logic              accept;
    logic              reject;
    logic [3:0]        be_next;
    logic [31:0]       wdata_next;

    // Captured access, held stable for the whole handshake
    logic              we_q;
    logic [29:0]       word_addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic              load_q;
    logic              signed_q;
    size_t             size_q;
    logic [1:0]        lane_q;
    logic              timed_out_q;

    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_ext;

    // Opcode decode: access size, direction and signedness
    always_comb begin
        op_is_mem  = 1'b1;
        op_is_load = 1'b0;
        op_signed  = 1'b0;
        op_size    = SZ_WORD;
        case (opcode)
            6'b100000: begin op_is_load = 1'b1; op_signed = 1'b1; op_size = SZ_BYTE; end
            6'b100001: begin op_is_load = 1'b1; op_signed = 1'b1; op_size = SZ_HALF; end
            6'b100011: begin op_is_load = 1'b1; op_size = SZ_WORD; end
            6'b100100: begin op_is_load = 1'b1; op_size = SZ_BYTE; end
            6'b100101: begin op_is_load = 1'b1; op_size = SZ_HALF; end
            6'b100111: begin op_is_load = 1'b1; op_size = SZ_WORD; end
            6'b101000: op_size = SZ_BYTE;
            6'b101001: op_size = SZ_HALF;
            6'b101011: op_size = SZ_WORD;
            default:   op_is_mem = 1'b0;
        endcase
    end

    // Alignment check and acceptance; reset gates acceptance so stall is quiet in reset
    always_comb begin
        addr_misaligned = 1'b0;
        if (op_size == SZ_HALF) begin
            addr_misaligned = addr[0];
        end else if (op_size == SZ_WORD) begin
            addr_misaligned = (addr[1:0] != 2'b00);
        end
        accept = reset && (state == IDLE) && req_valid && op_is_mem && !addr_misaligned;
        reject = (state == IDLE) && req_valid && op_is_mem && addr_misaligned;
    end

    // Store byte enables and lane-replicated write data; loads read the full word
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = 32'h0;
        if (!op_is_load) begin
            case (op_size)
                SZ_BYTE: begin
                    be_next    = 4'b0001 << addr[1:0];
                    wdata_next = {4{store_data[7:0]}};
                end
                SZ_HALF: begin
                    be_next    = addr[1] ? 4'b1100 : 4'b0011;
                    wdata_next = {2{store_data[15:0]}};
                end
                default: begin
                    be_next    = 4'b1111;
                    wdata_next = store_data;
                end
            endcase
        end
    end

    // Select and extend the addressed byte/halfword of the returned word
    always_comb begin
        case (lane_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            SZ_BYTE: load_ext = signed_q ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
            SZ_HALF: load_ext = signed_q ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake/pipeline control outputs
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        mem_req    = 1'b0;
        load_valid = 1'b0;
        bus_error  = 1'b0;
        case (state)
            IDLE: begin
                stall = accept;
                if (accept) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ack || (cnt == CNT_MAX)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                load_valid = load_q && !timed_out_q;
                bus_error  = timed_out_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Access capture, wait counter, load result and misalignment pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            we_q        <= 1'b0;
            word_addr_q <= '0;
            be_q        <= 4'b0;
            wdata_q     <= 32'h0;
            load_q      <= 1'b0;
            signed_q    <= 1'b0;
            size_q      <= SZ_BYTE;
            lane_q      <= 2'b0;
            timed_out_q <= 1'b0;
            load_data   <= 32'h0;
            misaligned  <= 1'b0;
        end else begin
            misaligned <= reject;
            if (accept) begin
                cnt         <= '0;
                we_q        <= !op_is_load;
                word_addr_q <= addr[31:2];
                be_q        <= be_next;
                wdata_q     <= wdata_next;
                load_q      <= op_is_load;
                signed_q    <= op_signed;
                size_q      <= op_size;
                lane_q      <= addr[1:0];
                timed_out_q <= 1'b0;
            end else if (state == ACCESS) begin
                if (mem_ack) begin
                    if (load_q) begin
                        load_data <= load_ext;
                    end
                end else if (cnt == CNT_MAX) begin
                    timed_out_q <= 1'b1;
                    if (load_q) begin
                        load_data <= 32'h0;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // Bus-side signals are driven only while a request is outstanding
    always_comb begin
        mem_we    = (state == ACCESS) && we_q;
        mem_addr  = (state == ACCESS) ? {word_addr_q, 2'b00} : 32'h0;
        mem_be    = (state == ACCESS) ? be_q : 4'b0;
        mem_wdata = (state == ACCESS) ? wdata_q : 32'h0;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl.
// Stimulus pushes hand-computed expected events into a queue; a monitor
// pops and compares whenever the DUT raises a request or a pulse.
module tb_mem_access_ctrl;

    localparam int TIMEOUT_CYC = 64;

    localparam int EV_REQ  = 0;
    localparam int EV_LOAD = 1;
    localparam int EV_MIS  = 2;
    localparam int EV_BERR = 3;

    typedef struct {
        int          kind;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [5:0]  opcode = 6'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        misaligned;
    logic        bus_error;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   stall_cnt = 0;
    int   req_cnt = 0;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LWU = 6'b100111;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    mem_access_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .opcode     (opcode),
        .addr       (addr),
        .store_data (store_data),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .misaligned (misaligned),
        .bus_error  (bus_error),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    // 10-unit clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    task automatic pushExp(input int kind, input logic we, input logic [31:0] a,
                           input logic [3:0] be, input logic [31:0] wd, input logic [31:0] d);
        exp_t e;
        e.kind = kind; e.we = we; e.addr = a; e.be = be; e.wdata = wd; e.data = d;
        sb.push_back(e);
    endtask

    task automatic handleEvent(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_event actual_kind=%0d required=none", kind);
        end else begin
            e = sb.pop_front();
            checkOutput("event_kind", kind, e.kind);
            if (kind == EV_REQ) begin
                checkOutput("mem_we", {31'h0, mem_we}, {31'h0, e.we});
                checkOutput("mem_addr", mem_addr, e.addr);
                checkOutput("mem_be", {28'h0, mem_be}, {28'h0, e.be});
                checkOutput("mem_wdata", mem_wdata, e.wdata);
            end else if (kind == EV_LOAD || kind == EV_BERR) begin
                checkOutput("load_data", load_data, e.data);
            end
        end
    endtask

    // Monitor: samples on the falling edge and matches DUT events against the scoreboard
    initial begin
        logic       req_prev;
        logic [2:0] pulse_prev;
        logic [2:0] pulses;
        req_prev   = 1'b0;
        pulse_prev = 3'b0;
        forever begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (mem_req) req_cnt++;
            pulses = {load_valid, misaligned, bus_error};
            if (reset) begin
                if (mem_req && !req_prev) handleEvent(EV_REQ);
                if (load_valid) handleEvent(EV_LOAD);
                if (misaligned) handleEvent(EV_MIS);
                if (bus_error) handleEvent(EV_BERR);
                if (pulses != 3'b0) begin
                    checkOutput("pulse_exclusive", $countones(pulses), 1);
                    checkOutput("pulse_width", {29'h0, pulses & pulse_prev}, 32'h0);
                end
            end
            req_prev   = mem_req;
            pulse_prev = pulses;
        end
    end

    // One aligned access: request, 'waits' cycles without ack, then ack with rdata
    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                                 input int waits, input logic [31:0] rdata, input bit is_load,
                                 input logic [31:0] exp_addr, input logic [3:0] exp_be,
                                 input logic [31:0] exp_wdata, input logic [31:0] exp_load);
        pushExp(EV_REQ, !is_load, exp_addr, exp_be, exp_wdata, 32'h0);
        if (is_load) pushExp(EV_LOAD, 1'b0, 32'h0, 4'h0, 32'h0, exp_load);
        @(posedge clk); #1;
        stall_cnt  = 0;
        req_cnt    = 0;
        req_valid  = 1'b1;
        opcode     = op;
        addr       = a;
        store_data = sd;
        @(posedge clk); #1;
        for (int i = 0; i < waits; i++) begin
            @(posedge clk); #1;
        end
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        opcode    = 6'h0;
        checkOutput("stall_cycles", stall_cnt, waits + 2);
        checkOutput("req_cycles", req_cnt, waits + 1);
    endtask

    // A single-cycle instruction that must not start an access
    task automatic applyNoAccess(input logic [5:0] op, input logic [31:0] a, input bit expect_mis);
        if (expect_mis) pushExp(EV_MIS, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        stall_cnt = 0;
        req_cnt   = 0;
        req_valid = 1'b1;
        opcode    = op;
        addr      = a;
        @(posedge clk); #1;
        req_valid = 1'b0;
        opcode    = 6'h0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        checkOutput("noaccess_stall", stall_cnt, 0);
        checkOutput("noaccess_req", req_cnt, 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] start");
        #3;
        checkOutput("reset_ctrl", {25'h0, stall, load_valid, misaligned, bus_error, mem_req, mem_we, 1'b0}, 32'h0);
        checkOutput("reset_load_data", load_data, 32'h0);
        checkOutput("reset_mem_addr", mem_addr, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Loads with extension
        applyStimulus(OP_LB,  32'h13,  32'h0, 3, 32'h80FF1234, 1, 32'h10,  4'hF, 32'h0, 32'hFFFFFF80);
        applyStimulus(OP_LH,  32'h102, 32'h0, 0, 32'hBEEF0000, 1, 32'h100, 4'hF, 32'h0, 32'hFFFFBEEF);
        applyStimulus(OP_LHU, 32'h102, 32'h0, 0, 32'hBEEF0000, 1, 32'h100, 4'hF, 32'h0, 32'h0000BEEF);

        // Stores do not disturb load_data
        applyStimulus(OP_SB,  32'h201, 32'h000000A5, 1, 32'h0, 0, 32'h200, 4'b0010, 32'hA5A5A5A5, 32'h0);
        checkOutput("store_keeps_load_data", load_data, 32'h0000BEEF);
        applyStimulus(OP_SH,  32'h102, 32'h1234CAFE, 0, 32'h0, 0, 32'h100, 4'b1100, 32'hCAFECAFE, 32'h0);
        applyStimulus(OP_SW,  32'h300, 32'hDEADBEEF, 2, 32'h0, 0, 32'h300, 4'b1111, 32'hDEADBEEF, 32'h0);
        checkOutput("store_keeps_load_data2", load_data, 32'h0000BEEF);

        applyStimulus(OP_LBU, 32'h21,  32'h0, 2, 32'h1234F6AB, 1, 32'h20,  4'hF, 32'h0, 32'h000000F6);
        applyStimulus(OP_LB,  32'h20,  32'h0, 0, 32'h1234F6AB, 1, 32'h20,  4'hF, 32'h0, 32'hFFFFFFAB);
        applyStimulus(OP_LW,  32'h44,  32'h0, 1, 32'h89ABCDEF, 1, 32'h44,  4'hF, 32'h0, 32'h89ABCDEF);
        applyStimulus(OP_LWU, 32'h48,  32'h0, 0, 32'h89ABCDEF, 1, 32'h48,  4'hF, 32'h0, 32'h89ABCDEF);

        // Misaligned and non-memory instructions
        applyNoAccess(OP_LW, 32'h06,  1);
        applyNoAccess(OP_LH, 32'h101, 1);
        applyNoAccess(OP_SW, 32'h202, 1);
        applyNoAccess(6'b000000, 32'h40, 0);
        checkOutput("misaligned_keeps_load_data", load_data, 32'h89ABCDEF);

        // Handshake timeout on a load
        pushExp(EV_REQ, 1'b0, 32'h80, 4'hF, 32'h0, 32'h0);
        pushExp(EV_BERR, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        stall_cnt = 0;
        req_cnt   = 0;
        req_valid = 1'b1;
        opcode    = OP_LW;
        addr      = 32'h80;
        @(posedge clk); #1;
        repeat (TIMEOUT_CYC) begin
            @(posedge clk); #1;
        end
        checkOutput("timeout_bus_error", {31'h0, bus_error}, 32'h1);
        checkOutput("timeout_stall_released", {31'h0, stall}, 32'h0);
        req_valid = 1'b0;
        opcode    = 6'h0;
        @(posedge clk); #1;
        checkOutput("timeout_req_cycles", req_cnt, TIMEOUT_CYC);
        checkOutput("timeout_stall_cycles", stall_cnt, TIMEOUT_CYC + 1);
        checkOutput("timeout_load_data", load_data, 32'h0);

        applyStimulus(OP_LW, 32'h84, 32'h0, 0, 32'h11223344, 1, 32'h84, 4'hF, 32'h0, 32'h11223344);

        // Reset in the middle of an access, then a late ack
        pushExp(EV_REQ, 1'b0, 32'h90, 4'hF, 32'h0, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b1;
        opcode    = OP_LW;
        addr      = 32'h90;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checkOutput("midreset_ctrl", {25'h0, stall, load_valid, misaligned, bus_error, mem_req, mem_we, 1'b0}, 32'h0);
        checkOutput("midreset_mem_addr", mem_addr, 32'h0);
        checkOutput("midreset_load_data", load_data, 32'h0);
        req_valid = 1'b0;
        opcode    = 6'h0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        checkOutput("late_ack_load_data", load_data, 32'h0);
        checkOutput("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
